bcd_display_scanner: RTL
========================

# bcd_display_scanner

Time-multiplexed scan controller for a multi-digit seven-segment display. Holds a packed multi-digit BCD value and presents one digit at a time on a shared BCD bus, together with a per-digit anode select. It sits directly upstream of the BCD-to-seven-segment decoder: it drives the decoder's BCD input and its active-low blank/enable input. New values are accepted through a ready/load handshake and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- DIGITS, 4, number of digits scanned (2..8).
- PRESCALE, 1000, clock cycles each digit is displayed (slot length); must be > GUARD.
- GUARD, 2, cycles at the start of each slot during which all anodes are off (ghosting suppression).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe: capture `value`; honoured only when `ready`=1.
- value  in  4*DIGITS  packed BCD; nibble i = digit i, digit 0 least significant (rightmost).
- lzb  in  1  leading-zero blanking enable; sampled every cycle.
- err_clr  in  1  clears the sticky `err` flag.
- ready  out  1  high when no committed-but-pending value is waiting.
- bcd  out  4  BCD code of the digit currently scanned.
- n_blank  out  1  active-low blank to the decoder; 1 = segments off.
- digit_sel  out  DIGITS  active-high anode select, at most one bit set.
- err  out  1  sticky: an invalid nibble (>9) has been scanned.

## Operation
- Registers: slot counter `pcnt` (0..PRESCALE-1), digit index `idx` (0..DIGITS-1), shadow register, display register `disp`, `pending` flag, `err`.
- `pcnt` increments every cycle; at PRESCALE-1 it wraps to 0 and `idx` advances; `idx` DIGITS-1 → 0 is the frame wrap.
- Load: when `load`=1 and `ready`=1, shadow ← value and pending ← 1. `load` with `ready`=0 is ignored (shadow unchanged, no error).
- Commit: on the cycle `idx` wraps to 0, if pending=1 then disp ← shadow and pending ← 0. A load accepted in the same cycle as a frame wrap is not committed by that wrap; it commits at the next wrap.
- `ready` = ~pending.
- Digit output for index i: bcd = disp nibble i.
- Blanking (n_blank=1) for digit i when any of:
  - nibble i > 9 (bcd still shows the raw nibble);
  - lzb=1, i ≠ 0, and nibbles DIGITS-1 down to i are all zero. Digit 0 is never blanked for zeros.
- digit_sel: bit idx set when pcnt ≥ GUARD, all zero otherwise.
- err: set on any cycle where the scanned nibble is > 9; cleared by err_clr; simultaneous set and clear leaves err=1.

## Timing
- All outputs are registered; each reflects `pcnt`, `idx` and `disp` from the previous cycle (1-cycle latency).
- Reset values: pcnt=0, idx=0, disp=0, shadow=0, pending=0; outputs ready=1, bcd=0, n_blank=1, digit_sel=0, err=0.
- First edge after reset release: outputs show digit 0, value 0, n_blank=0 (with lzb=1, digit 0 is still shown), digit_sel=0 (guard).
- Slot length is exactly PRESCALE cycles; frame length is DIGITS*PRESCALE cycles.
- Within each slot, digit_sel is high for PRESCALE-GUARD cycles.
- Load-to-display latency: from the accepting edge, up to one full frame until commit, then 1 cycle until outputs change.
- Reset asserted mid-frame forces all registers to their reset values immediately (asynchronous) and discards any pending value. Scanning restarts at digit 0.

## Test plan
Test parameters: DIGITS=4, PRESCALE=4, GUARD=1.
- Reset, then free run for 32 cycles. Required: digit_sel follows 0000 then 0001 ×3, 0000 then 0010 ×3, through 1000, repeating. bcd=0 throughout, ready=1, err=0.
- Load value=16'h1234 mid-frame. Required: ready=0 until the next wrap; then digits 0..3 show bcd 4,3,2,1 with n_blank=0, and ready returns to 1.
- Set lzb=1 and load 16'h0050. Required: digits 3 and 2 have n_blank=1; digit 1 shows bcd=5 and digit 0 shows bcd=0, both with n_blank=0. Load 16'h0000: only digit 0 is unblanked.
- Load 16'h12A4. Required: digit 1 has n_blank=1 and err=1, and err stays 1 after the value is replaced. Pulse err_clr while digit 1 is scanned: err stays 1. Pulse err_clr after loading 16'h1234 and that value has committed: err=0.
- Second load while ready=0. Required: ignored, first value committed. Load coinciding with a wrap cycle while pending=0: committed one frame later.
- Assert reset while pending=1 mid-frame. Required: all outputs return to their reset values at once, and the pending value never appears.

Source files
------------

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner
// Brief    : Time-multiplexed scan controller for a multi-digit seven-segment
//            display. Presents one BCD digit at a time with an anode select,
//            blanking and a sticky invalid-digit flag. New values are taken
//            through a ready/load handshake and committed on frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lzb,
  input  logic                  err_clr,
  output logic                  ready,
  output logic [3:0]            bcd,
  output logic                  n_blank,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  err
);

  localparam int                c_pw        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int                c_iw        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_pw-1:0]   c_pcnt_max  = c_pw'(PRESCALE - 1);
  localparam logic [c_pw-1:0]   c_guard     = c_pw'(GUARD);
  localparam logic [c_iw-1:0]   c_idx_max   = c_iw'(DIGITS - 1);
  localparam logic [DIGITS-1:0] c_sel_one   = DIGITS'(1);

  logic [c_pw-1:0]     r_pcnt;
  logic [c_iw-1:0]     r_idx;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_pending;

  logic                w_slot_end;
  logic                w_frame_wrap;
  logic [4*DIGITS-1:0] w_shift;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_nz;
  logic                w_upper_zero;
  logic                w_bad;
  logic                w_blank;

  assign w_slot_end   = (r_pcnt == c_pcnt_max);
  assign w_frame_wrap = w_slot_end && (r_idx == c_idx_max);
  assign ready        = ~r_pending;

  // Select the current digit and decide whether it must be blanked
  always_comb begin
    w_shift = r_disp >> {r_idx, 2'b00};
    w_nib   = w_shift[3:0];
    w_nz    = '0;
    for (int j = 0; j < DIGITS; j++) begin
      w_nz[j] = (r_disp[j*4 +: 4] != 4'd0);
    end
    // Digits from the current index up to the MSD are all zero
    w_upper_zero = ~|(w_nz >> r_idx);
    w_bad        = (w_nib > 4'd9);
    w_blank      = w_bad || (lzb && (r_idx != '0) && w_upper_zero);
  end

  // Slot counter and digit index; index wraps at the end of a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (w_slot_end) begin
      r_pcnt <= '0;
      r_idx  <= (r_idx == c_idx_max) ? '0 : r_idx + c_iw'(1);
    end else begin
      r_pcnt <= r_pcnt + c_pw'(1);
    end
  end

  // Load handshake into the shadow register, commit to display on frame wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else if (r_pending) begin
      // While pending, loads are refused; only the frame wrap can clear it
      if (w_frame_wrap) begin
        r_disp    <= r_shadow;
        r_pending <= 1'b0;
      end
    end else if (load) begin
      r_shadow  <= value;
      r_pending <= 1'b1;
    end
  end

  // Registered display outputs, one cycle behind the scan state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd       <= 4'd0;
      n_blank   <= 1'b1;
      digit_sel <= '0;
    end else begin
      bcd       <= w_nib;
      n_blank   <= w_blank;
      digit_sel <= (r_pcnt >= c_guard) ? (c_sel_one << r_idx) : '0;
    end
  end

  // Sticky invalid-digit flag; a new error wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (w_bad) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
`default_nettype wire
